grid_router_tx_framer: RTL and testbench
========================================

# grid_router_tx_framer

Parametrised multi-lane transmit framer for the grid router link, generalising the fixed three-lane encoder front end. It accepts wide data words over a valid/ready handshake and buffers them in a FIFO. It emits one framed symbol per lane per serializer symbol strobe, sequencing link training, periodic lane-sync symbols, and idle fill. It sits between the router output port and the per-lane serial output stages, all in the parallel clock domain.

## Interface
- LANES, 3, number of serial lanes (1..8)
- DW, 6, payload bits per lane per symbol (>=2)
- DEPTH, 8, FIFO depth in words (power of 2, >=2)
- TRAIN_LEN, 64, training symbols per training sequence (>=2)
- SYNC_INT, 256, RUN symbols between sync symbols (>=2)
- clk  in  1  parallel clock; the only clock
- rst  in  1  reset; synchronous, active-high
- sym_ce  in  1  one-cycle strobe from the serializers: load the next symbol
- retrain  in  1  one-cycle request to restart training
- i_dat  in  LANES*DW  data word; lane i uses i_dat[i*DW +: DW]
- i_valid  in  1  i_dat valid
- i_ready  out  1  FIFO can accept a word
- o_sym  out  LANES*(DW+2)  lane i symbol at o_sym[i*(DW+2) +: DW+2]; header = [DW+1:DW], payload = [DW-1:0]
- link_up  out  1  high in RUN
- fifo_cnt  out  $clog2(DEPTH)+1  words held

## Operation
- Symbol header 2'b01 marks data. Header 2'b10 marks control. Headers 00 and 11 are never produced.
- Control payloads:
  - IDLE = all zeros.
  - SYNC = all ones.
  - TRAIN_A = 1010… with the MSB set to 1.
  - TRAIN_B = ~TRAIN_A.
- All lanes carry the same control symbol in any given slot.
- FIFO:
  - i_ready = !rst && fifo_cnt < DEPTH. There is no pass-through when full.
  - A push occurs when i_valid && i_ready.
  - A pop occurs only in a RUN data slot with fifo_cnt > 0.
  - fifo_cnt updates by +push −pop. A simultaneous push and pop leaves the count unchanged.
  - Pop decisions use the pre-push count, so a word pushed on a sym_ce cycle into an empty FIFO is not sent in that slot.
  - The FIFO accepts words in every state, including TRAIN.
- State machine, with state changes only on sym_ce or retrain:
  - TRAIN: on each sym_ce, emit TRAIN_A if tcnt is even, otherwise TRAIN_B. tcnt increments. After emitting the symbol with tcnt = TRAIN_LEN−1, go to RUN with scnt = 0.
  - RUN: on each sym_ce, the slot is filled by the first matching rule:
    - if scnt == 0, emit SYNC;
    - else if fifo_cnt > 0, pop and emit data (header 01, lane slices of the head word);
    - else emit IDLE.
    - scnt then increments modulo SYNC_INT.
- retrain:
  - Takes effect in the cycle it is sampled: state becomes TRAIN with tcnt = 0.
  - If it coincides with sym_ce, the symbol loaded is TRAIN_A and tcnt becomes 1, regardless of the current state.
  - No pop occurs in that cycle.
  - FIFO contents are preserved.
  - retrain during TRAIN restarts the count.
- Reset:
  - state TRAIN, tcnt = 0, scnt = 0, FIFO empty.
  - o_sym = IDLE on all lanes (each lane {2'b10, DW'b0}).
  - link_up = 0, fifo_cnt = 0, i_ready = 0 while rst is high.
  - Reset mid-operation discards FIFO contents.

## Timing
- o_sym is registered. It changes only on the clock edge where sym_ce = 1 (or on reset) and holds otherwise.
- link_up is registered and rises on the edge that loads the first RUN symbol (a SYNC).
- Latency from acceptance to output:
  - A word accepted on edge n is eligible at the first RUN data slot whose sym_ce cycle is ≥ n+1.
  - It appears on o_sym one edge after that sym_ce cycle.
- fifo_cnt and i_ready reflect post-edge state. i_ready is combinational from fifo_cnt and rst.
- sym_ce on consecutive cycles is legal. Each such cycle is one slot.

## Test plan
- Reset, then sym_ce every 4th cycle, no data, LANES=3, DW=6, TRAIN_LEN=4, SYNC_INT=4:
  - o_sym lanes read 0x AA, 95, AA, 95 (TRAIN_A = 2'b10+101010, TRAIN_B = 2'b10+010101);
  - then SYNC (0xBF) with link_up rising on that edge;
  - then IDLE 0x80 ×3, then SYNC.
- In RUN, push words 0x00001, 0x3FFFF and 0x15555:
  - data slots carry header 01 with the correct lane slices, in order;
  - the sync slot is never used for data and data resumes after it;
  - fifo_cnt returns to 0.
- Hold sym_ce low and push until full with DEPTH=8:
  - i_ready drops after the 8th accept and fifo_cnt = 8;
  - a 9th word held on i_valid is not accepted until a pop occurs.
- Push into an empty FIFO on the same cycle as a RUN data-slot sym_ce:
  - that slot emits IDLE;
  - the next data slot emits the word.
- Assert retrain together with sym_ce in RUN with 3 words queued:
  - the loaded symbol is TRAIN_A and link_up falls;
  - fifo_cnt stays 3 through TRAIN_LEN symbols;
  - after the SYNC, all 3 words emerge in order.
- Assert rst mid-RUN with a non-empty FIFO:
  - next cycle o_sym = IDLE on all lanes, fifo_cnt = 0, link_up = 0;
  - training restarts from TRAIN_A.

Source files
------------

// File: rtl/grid_router_tx_framer.sv
// grid_router_tx_framer: multi-lane transmit framer for the grid router link.
// Buffers wide data words in a FIFO and emits one framed symbol per lane on
// every serializer strobe. It sequences link training, periodic lane-sync
// symbols, data and idle fill.
//
// Ports
//   clk       parallel clock
//   rst       synchronous active-high reset
//   sym_ce    serializer strobe: load the next symbol
//   retrain   one-cycle request to restart training
//   i_dat     data word, lane i at [i*DW +: DW]
//   i_valid   i_dat valid
//   i_ready   FIFO can accept a word (combinational)
//   o_sym     lane i symbol at [i*(DW+2) +: DW+2], header in the top two bits
//   link_up   high while running
//   fifo_cnt  words held
module grid_router_tx_framer #(
    parameter int unsigned LANES     = 3,
    parameter int unsigned DW        = 6,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned TRAIN_LEN = 64,
    parameter int unsigned SYNC_INT  = 256
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sym_ce,
    input  logic                          retrain,
    input  logic [LANES*DW-1:0]           i_dat,
    input  logic                          i_valid,
    output logic                          i_ready,
    output logic [LANES*(DW+2)-1:0]       o_sym,
    output logic                          link_up,
    output logic [$clog2(DEPTH):0]        fifo_cnt
);

    localparam int unsigned SW = DW + 2;
    localparam int unsigned WW = LANES * DW;
    localparam int unsigned OW = LANES * SW;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned TW = $clog2(TRAIN_LEN);
    localparam int unsigned CW = $clog2(SYNC_INT);

    localparam logic [0:0] ST_TRAIN = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    // Alternating 1010... pattern with the payload MSB set
    function automatic logic [DW-1:0] train_a_f();
        logic [DW-1:0] v;
        for (int b = 0; b < int'(DW); b++) begin
            v[b] = (((int'(DW) - 1 - b) % 2) == 0);
        end
        return v;
    endfunction

    localparam logic [DW-1:0] TRAIN_A  = train_a_f();
    localparam logic [SW-1:0] SYM_IDLE = {2'b10, {DW{1'b0}}};
    localparam logic [SW-1:0] SYM_SYNC = {2'b10, {DW{1'b1}}};
    localparam logic [SW-1:0] SYM_TA   = {2'b10, TRAIN_A};
    localparam logic [SW-1:0] SYM_TB   = {2'b10, ~TRAIN_A};

    logic [0:0]    r_state, w_state_nx;
    logic [TW-1:0] r_tcnt,  w_tcnt_nx;
    logic [CW-1:0] r_scnt,  w_scnt_nx;
    logic [OW-1:0] r_sym,   w_sym_nx;
    logic          r_link,  w_link_nx;
    logic [AW-1:0] r_wptr,  r_rptr;
    logic [AW:0]   r_cnt;
    logic [WW-1:0] r_mem [DEPTH];
    logic [WW-1:0] w_head;
    logic          w_push, w_pop;

    assign i_ready  = !rst && (r_cnt < (AW+1)'(DEPTH));
    assign w_push   = i_valid && i_ready;
    assign w_head   = r_mem[r_rptr];
    assign o_sym    = r_sym;
    assign link_up  = r_link;
    assign fifo_cnt = r_cnt;

    // FIFO storage; contents need no reset, the pointers and count qualify them
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_dat;
        end
    end

    // Slot sequencing: retrain wins over the normal strobe behaviour
    always_comb begin
        w_state_nx = r_state;
        w_tcnt_nx  = r_tcnt;
        w_scnt_nx  = r_scnt;
        w_sym_nx   = r_sym;
        w_link_nx  = r_link;
        w_pop      = 1'b0;
        if (retrain) begin
            w_state_nx = ST_TRAIN;
            w_tcnt_nx  = '0;
            w_link_nx  = 1'b0;
            if (sym_ce) begin
                w_sym_nx  = {LANES{SYM_TA}};
                w_tcnt_nx = TW'(1);
            end
        end else if (sym_ce) begin
            case (r_state)
                ST_TRAIN: begin
                    w_sym_nx = r_tcnt[0] ? {LANES{SYM_TB}} : {LANES{SYM_TA}};
                    if (r_tcnt == TW'(TRAIN_LEN - 1)) begin
                        w_state_nx = ST_RUN;
                        w_tcnt_nx  = '0;
                        w_scnt_nx  = '0;
                    end else begin
                        w_tcnt_nx = r_tcnt + TW'(1);
                    end
                end
                default: begin
                    // link_up rises with the first RUN symbol, not on entry
                    w_link_nx = 1'b1;
                    if (r_scnt == '0) begin
                        w_sym_nx = {LANES{SYM_SYNC}};
                    end else if (r_cnt != '0) begin
                        w_pop = 1'b1;
                        for (int i = 0; i < int'(LANES); i++) begin
                            w_sym_nx[i*SW +: SW] = {2'b01, w_head[i*DW +: DW]};
                        end
                    end else begin
                        w_sym_nx = {LANES{SYM_IDLE}};
                    end
                    w_scnt_nx = (r_scnt == CW'(SYNC_INT - 1)) ? '0 : r_scnt + CW'(1);
                end
            endcase
        end
    end

    // State, symbol and FIFO pointer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_TRAIN;
            r_tcnt  <= '0;
            r_scnt  <= '0;
            r_sym   <= {LANES{SYM_IDLE}};
            r_link  <= 1'b0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_tcnt  <= w_tcnt_nx;
            r_scnt  <= w_scnt_nx;
            r_sym   <= w_sym_nx;
            r_link  <= w_link_nx;
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

endmodule

// File: tb/tb_grid_router_tx_framer.sv
// tb_grid_router_tx_framer: self-checking bench for grid_router_tx_framer.
// Accepted words go into a scoreboard queue; each data slot pops the head
// word and compares the lane-sliced symbol, control slots compare constants.
module tb_grid_router_tx_framer;

    localparam int unsigned LANES     = 3;
    localparam int unsigned DW        = 6;
    localparam int unsigned DEPTH     = 8;
    localparam int unsigned TRAIN_LEN = 4;
    localparam int unsigned SYNC_INT  = 4;
    localparam int unsigned SW        = DW + 2;
    localparam int unsigned WW        = LANES * DW;
    localparam int unsigned OW        = LANES * SW;

    localparam logic [OW-1:0] S_TA = 24'hAAAAAA;
    localparam logic [OW-1:0] S_TB = 24'h959595;
    localparam logic [OW-1:0] S_SY = 24'hBFBFBF;
    localparam logic [OW-1:0] S_ID = 24'h808080;
    localparam int K_CTL = 0;
    localparam int K_DAT = 1;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  sym_ce = 1'b0;
    logic                  retrain = 1'b0;
    logic [WW-1:0]         i_dat = '0;
    logic                  i_valid = 1'b0;
    logic                  i_ready;
    logic [OW-1:0]         o_sym;
    logic                  link_up;
    logic [$clog2(DEPTH):0] fifo_cnt;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [WW-1:0] wq[$];
    logic [WW-1:0] w9;
    logic [WW-1:0] wx;

    grid_router_tx_framer #(
        .LANES(LANES), .DW(DW), .DEPTH(DEPTH),
        .TRAIN_LEN(TRAIN_LEN), .SYNC_INT(SYNC_INT)
    ) dut (
        .clk(clk), .rst(rst), .sym_ce(sym_ce), .retrain(retrain),
        .i_dat(i_dat), .i_valid(i_valid), .i_ready(i_ready),
        .o_sym(o_sym), .link_up(link_up), .fifo_cnt(fifo_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish, got running need done");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [OW-1:0] dsym(input logic [WW-1:0] w);
        logic [OW-1:0] r;
        for (int i = 0; i < int'(LANES); i++) begin
            r[i*SW +: SW] = {2'b01, w[i*DW +: DW]};
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a word until accepted (bounded), record it in the scoreboard
    task automatic push_word(input logic [WW-1:0] w);
        bit acc;
        acc = 1'b0;
        i_dat = w;
        i_valid = 1'b1;
        for (int k = 0; k < 32; k++) begin
            acc = i_ready;
            step();
            if (acc) break;
        end
        i_valid = 1'b0;
        if (acc) wq.push_back(w);
        else chk("push_timeout", 64'(acc), 64'd1);
    endtask

    // One symbol slot: strobe, compare the loaded symbol, then check it holds
    task automatic slot(input int kind, input logic [OW-1:0] ctl, input bit rt,
                        input int gap, input string tag);
        logic [OW-1:0] e;
        sym_ce = 1'b1;
        retrain = rt;
        step();
        sym_ce = 1'b0;
        retrain = 1'b0;
        e = ctl;
        if (kind == K_DAT) begin
            if (wq.size() == 0) begin
                chk({tag, "_sb_empty"}, 64'(wq.size()), 64'd1);
                return;
            end
            e = dsym(wq.pop_front());
        end
        chk(tag, 64'(o_sym), 64'(e));
        repeat (gap) step();
        if (gap > 0) chk({tag, "_hold"}, 64'(o_sym), 64'(e));
    endtask

    initial begin
        // Reset state
        repeat (3) step();
        chk("rst_sym", 64'(o_sym), 64'(S_ID));
        chk("rst_link", 64'(link_up), 64'd0);
        chk("rst_cnt", 64'(fifo_cnt), 64'd0);
        chk("rst_rdy", 64'(i_ready), 64'd0);
        rst = 1'b0;
        step();
        chk("rdy_after_rst", 64'(i_ready), 64'd1);

        // Training, first sync, idle fill
        slot(K_CTL, S_TA, 1'b0, 3, "tr0");
        slot(K_CTL, S_TB, 1'b0, 3, "tr1");
        slot(K_CTL, S_TA, 1'b0, 3, "tr2");
        slot(K_CTL, S_TB, 1'b0, 3, "tr3");
        chk("link_pre", 64'(link_up), 64'd0);
        slot(K_CTL, S_SY, 1'b0, 0, "sync0");
        chk("link_rise", 64'(link_up), 64'd1);
        repeat (3) step();
        for (int i = 0; i < 3; i++) slot(K_CTL, S_ID, 1'b0, 3, "idle");
        slot(K_CTL, S_SY, 1'b0, 3, "sync1");

        // Data in order, skipping the sync slot
        push_word(18'h00001);
        push_word(18'h3FFFF);
        push_word(18'h15555);
        push_word(18'h2A0C3);
        chk("cnt4", 64'(fifo_cnt), 64'd4);
        slot(K_DAT, '0, 1'b0, 3, "d0");
        slot(K_DAT, '0, 1'b0, 3, "d1");
        slot(K_DAT, '0, 1'b0, 3, "d2");
        slot(K_CTL, S_SY, 1'b0, 3, "d_sync");
        slot(K_DAT, '0, 1'b0, 3, "d3");
        slot(K_CTL, S_ID, 1'b0, 3, "d_idle");
        chk("cnt_drained", 64'(fifo_cnt), 64'd0);

        // Fill to DEPTH with the strobe held low
        for (int i = 0; i < int'(DEPTH); i++) push_word(18'($urandom_range(0, 262143)));
        chk("full_cnt", 64'(fifo_cnt), 64'(DEPTH));
        chk("full_rdy", 64'(i_ready), 64'd0);
        w9 = 18'h0F0F0;
        i_dat = w9;
        i_valid = 1'b1;
        repeat (3) step();
        chk("full_hold_cnt", 64'(fifo_cnt), 64'(DEPTH));
        slot(K_DAT, '0, 1'b0, 0, "full_pop");
        chk("pop_cnt", 64'(fifo_cnt), 64'(DEPTH - 1));
        chk("pop_rdy", 64'(i_ready), 64'd1);
        step();
        i_valid = 1'b0;
        wq.push_back(w9);
        chk("ninth_cnt", 64'(fifo_cnt), 64'(DEPTH));
        slot(K_CTL, S_SY, 1'b0, 3, "f_sync0");
        for (int i = 0; i < 3; i++) slot(K_DAT, '0, 1'b0, 3, "f_dat");
        slot(K_CTL, S_SY, 1'b0, 3, "f_sync1");
        for (int i = 0; i < 2; i++) slot(K_DAT, '0, 1'b0, 3, "f_dat");
        chk("pre_rt_cnt", 64'(fifo_cnt), 64'd3);

        // Retrain with the strobe, three words queued
        slot(K_CTL, S_TA, 1'b1, 3, "rt_ta");
        chk("rt_link", 64'(link_up), 64'd0);
        chk("rt_cnt0", 64'(fifo_cnt), 64'd3);
        slot(K_CTL, S_TB, 1'b0, 3, "rt_tb1");
        slot(K_CTL, S_TA, 1'b0, 3, "rt_ta2");
        slot(K_CTL, S_TB, 1'b0, 3, "rt_tb3");
        chk("rt_cnt3", 64'(fifo_cnt), 64'd3);
        chk("rt_link_pre", 64'(link_up), 64'd0);
        slot(K_CTL, S_SY, 1'b0, 3, "rt_sync");
        chk("rt_link_up", 64'(link_up), 64'd1);
        for (int i = 0; i < 3; i++) slot(K_DAT, '0, 1'b0, 3, "rt_dat");
        chk("rt_cnt_end", 64'(fifo_cnt), 64'd0);
        slot(K_CTL, S_SY, 1'b0, 3, "rt_sync2");

        // Push into an empty FIFO on a data-slot strobe
        wx = 18'h2D2D2;
        i_dat = wx;
        i_valid = 1'b1;
        slot(K_CTL, S_ID, 1'b0, 0, "emp_idle");
        i_valid = 1'b0;
        wq.push_back(wx);
        chk("emp_cnt", 64'(fifo_cnt), 64'd1);
        repeat (2) step();
        slot(K_DAT, '0, 1'b0, 3, "emp_data");
        chk("emp_cnt0", 64'(fifo_cnt), 64'd0);

        // Reset mid-run with a non-empty FIFO
        push_word(18'h11111);
        push_word(18'h22222);
        chk("prerst_cnt", 64'(fifo_cnt), 64'd2);
        rst = 1'b1;
        step();
        chk("mrst_sym", 64'(o_sym), 64'(S_ID));
        chk("mrst_cnt", 64'(fifo_cnt), 64'd0);
        chk("mrst_link", 64'(link_up), 64'd0);
        chk("mrst_rdy", 64'(i_ready), 64'd0);
        rst = 1'b0;
        wq.delete();
        step();
        slot(K_CTL, S_TA, 1'b0, 3, "mrst_ta");
        slot(K_CTL, S_TB, 1'b0, 3, "mrst_tb");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
